// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_pkg                                                               |
// | Shared types and constants for the PC sequencer.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pc_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } pcState_t;

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_target_calc                                                       |
// | Combinational branch and jump target computation.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_target_calc
    import pc_pkg::*;
(
    input  logic [PC_W-1:0] ctl_pc,
    input  logic [15:0]     branch_imm,
    input  logic [25:0]     jump_addr,
    output logic [PC_W-1:0] btarget,
    output logic [PC_W-1:0] jtarget
);

    logic [PC_W-1:0] w_ctlPcPlus4;
    logic [PC_W-1:0] w_branchOff;

    assign w_ctlPcPlus4 = ctl_pc + PC_W'(INSTR_BYTES);
    // Word offset, sign-extended and scaled to bytes
    assign w_branchOff  = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign btarget      = w_ctlPcPlus4 + w_branchOff;
    assign jtarget      = {w_ctlPcPlus4[31:28], jump_addr, 2'b00};

endmodule
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_next_unit                                                         |
// | PC register, next-PC FSM and redirect flush timer.                   |
// | Optional macro PC_ALIGN_CHECK_EN adds the misaligned-target trap.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_next_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic [PC_W-1:0] ctl_pc,
    input  logic [15:0]     branch_imm,
    input  logic [25:0]     jump_addr,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            flush,
    output logic            halted
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            misaligned
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] c_FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pcState_t               r_state;
    pcState_t               w_stateNext;
    logic [PC_W-1:0]        r_pc;
    logic [PC_W-1:0]        w_pcNext;
    logic [FLUSH_CNT_W-1:0] r_flushCnt;
    logic [FLUSH_CNT_W-1:0] w_flushCntNext;
    logic                   r_flush;
    logic                   r_halted;
    logic [PC_W-1:0]        w_btarget;
    logic [PC_W-1:0]        w_jtarget;
    logic [PC_W-1:0]        w_target;
    logic [PC_W-1:0]        w_pcPlus4;
`ifdef PC_ALIGN_CHECK_EN
    logic                   r_misaligned;
    logic                   w_misalignedNext;
`endif

    pc_target_calc u_targetCalc (
        .ctl_pc     (ctl_pc),
        .branch_imm (branch_imm),
        .jump_addr  (jump_addr),
        .btarget    (w_btarget),
        .jtarget    (w_jtarget)
    );

    assign w_pcPlus4 = r_pc + PC_W'(INSTR_BYTES);
    // Jump outranks a simultaneous taken branch
    assign w_target  = jump ? w_jtarget : w_btarget;

    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_flushCntNext = r_flushCnt;
`ifdef PC_ALIGN_CHECK_EN
        w_misalignedNext = r_misaligned;
`endif
        case (r_state)
            RUN: begin
                if (halt_req) begin
                    w_stateNext = HALT;
                end else if (stall) begin
                    w_stateNext = RUN;
                end else if (jump || branch_taken) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (w_target[1:0] != 2'b00) begin
                        w_stateNext      = HALT;
                        w_misalignedNext = 1'b1;
                    end else
`endif
                    begin
                        w_pcNext       = w_target;
                        w_stateNext    = FLUSH;
                        w_flushCntNext = c_FLUSH_LOAD;
                    end
                end else begin
                    w_pcNext = w_pcPlus4;
                end
            end
            FLUSH: begin
                // Redirect and halt requests here come from wrong-path instructions
                if (!stall) begin
                    w_pcNext = w_pcPlus4;
                    if (r_flushCnt == '0) begin
                        w_stateNext = RUN;
                    end else begin
                        w_flushCntNext = r_flushCnt - 1'b1;
                    end
                end
            end
            HALT: begin
                w_stateNext = HALT;
            end
            default: begin
                w_stateNext = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_flushCnt <= '0;
            r_flush    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_flushCnt <= w_flushCntNext;
            r_flush    <= (w_stateNext == FLUSH);
            r_halted   <= (w_stateNext == HALT);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_misalignedNext;
        end
    end

    assign misaligned = r_misaligned;
`endif

    assign pc       = r_pc;
    assign pc_plus4 = w_pcPlus4;
    assign flush    = r_flush;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_next_unit                                                      |
// | Directed scoreboard bench for pc_next_unit (RESET_PC=0x400000,       |
// | FLUSH_CYCLES=2). Misaligned checks build with PC_ALIGN_CHECK_EN.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pc_next_unit;

    localparam logic [31:0] c_RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, halt_req;
    logic [31:0] ctl_pc;
    logic [15:0] branch_imm;
    logic [25:0] jump_addr;
    logic [31:0] pc, pc_plus4;
    logic        flush, halted;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        flush;
        logic        halted;
    } exp_t;

    exp_t sbq[$];
    int   passCnt  = 0;
    int   failCnt  = 0;
    int   totalCnt = 0;

    pc_next_unit #(
        .RESET_PC     (c_RST_PC),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .ctl_pc       (ctl_pc),
        .branch_imm   (branch_imm),
        .jump_addr    (jump_addr),
        .halt_req     (halt_req),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .flush        (flush),
        .halted       (halted)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned   (misaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        totalCnt++;
        assert (got === expv) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic pushExp(input logic [31:0] ePc, input logic eFl, input logic eHt);
        exp_t e;
        e.pc     = ePc;
        e.flush  = eFl;
        e.halted = eHt;
        sbq.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            totalCnt++;
            failCnt++;
            $error("FAIL %s: scoreboard empty, observed pc %h", tag, pc);
            return;
        end
        e = sbq.pop_front();
        chk({tag, ".pc"},       pc,              e.pc);
        chk({tag, ".pc_plus4"}, pc_plus4,        e.pc + 32'd4);
        chk({tag, ".flush"},    {31'd0, flush},  {31'd0, e.flush});
        chk({tag, ".halted"},   {31'd0, halted}, {31'd0, e.halted});
    endtask

    task automatic step(input string tag, input logic st, input logic bt, input logic jp,
                        input logic hr, input logic [31:0] cpc, input logic [15:0] imm,
                        input logic [25:0] ja, input logic [31:0] ePc, input logic eFl,
                        input logic eHt);
        stall        = st;
        branch_taken = bt;
        jump         = jp;
        halt_req     = hr;
        ctl_pc       = cpc;
        branch_imm   = imm;
        jump_addr    = ja;
        pushExp(ePc, eFl, eHt);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic idle(input string tag, input logic [31:0] ePc, input logic eFl, input logic eHt);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, ePc, eFl, eHt);
    endtask

    task automatic doReset(input string tag);
        rst_n        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        halt_req     = 1'b0;
        #2;
        pushExp(c_RST_PC, 1'b0, 1'b0);
        compare(tag);
`ifdef PC_ALIGN_CHECK_EN
        chk({tag, ".misaligned"}, {31'd0, misaligned}, 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ctl_pc = '0; branch_imm = '0; jump_addr = '0;
        #7;
        doReset("reset");
        #5;

        idle("seq0", 32'h0040_0004, 1'b0, 1'b0);
        idle("seq1", 32'h0040_0008, 1'b0, 1'b0);
        idle("seq2", 32'h0040_000C, 1'b0, 1'b0);

        // Backward branch, then a wrong-path branch inside FLUSH
        step("br_neg", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 16'hFFFE, 26'h0, 32'h0000_00FC, 1'b1, 1'b0);
        step("br_wp",  1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 16'h0010, 26'h0, 32'h0000_0100, 1'b1, 1'b0);
        idle("br_end", 32'h0000_0104, 1'b0, 1'b0);

        // Jump beats branch; then 3 stalled FLUSH cycles
        step("jmp_br", 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0010, 16'h0004, 26'h40, 32'h1000_0100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("fl_stall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h1000_0100, 1'b1, 1'b0);
        idle("fl_last", 32'h1000_0104, 1'b1, 1'b0);
        idle("fl_exit", 32'h1000_0108, 1'b0, 1'b0);

        step("run_stall", 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 16'h0, 26'h10, 32'h1000_0108, 1'b0, 1'b0);

        // Forward branch, halt_req during FLUSH is ignored
        step("br_pos",  1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 16'h0010, 26'h0, 32'h0000_0244, 1'b1, 1'b0);
        step("fl_halt", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 16'h0, 26'h0, 32'h0000_0248, 1'b1, 1'b0);
        idle("fl_halt_end", 32'h0000_024C, 1'b0, 1'b0);

        // Sequential wrap past 0xFFFF_FFFC
        step("br_top", 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 16'h0002, 26'h0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        idle("wrap0", 32'h0000_0000, 1'b1, 1'b0);
        idle("wrap1", 32'h0000_0004, 1'b0, 1'b0);

        // Halt is absorbing
        step("halt",    1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 16'h0, 26'h0, 32'h0000_0004, 1'b0, 1'b1);
        step("halt_j",  1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 16'h1, 26'h99, 32'h0000_0004, 1'b0, 1'b1);
        idle("halt_hold", 32'h0000_0004, 1'b0, 1'b1);
        doReset("rst_halt");
        idle("post_rst", 32'h0040_0004, 1'b0, 1'b0);

        step("br_zero", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 16'h0000, 26'h0, 32'h0000_0104, 1'b1, 1'b0);
        doReset("rst_flush");
        idle("post_rst2", 32'h0040_0004, 1'b0, 1'b0);

`ifdef PC_ALIGN_CHECK_EN
        step("misal", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 16'h0000, 26'h0, 32'h0040_0004, 1'b0, 1'b1);
        chk("misal.flag", {31'd0, misaligned}, 32'd1);
        idle("misal_hold", 32'h0040_0004, 1'b0, 1'b1);
        chk("misal.sticky", {31'd0, misaligned}, 32'd1);
`endif

        if (sbq.size() != 0) begin
            totalCnt++;
            failCnt++;
            $error("FAIL sb_drain: observed %0d left expected 0", sbq.size());
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
